fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 121 ++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction fetch unit with a 4-entry {pc, instr} FIFO.
//               Issues sequential fetches while free space remains, flushes
//               and refetches on redirect, and presents the head to decode.
//               Optional empty-queue bypass is selected by FETCHQ_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        stall,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    output logic        inst_valid,
    output logic [2:0]  occupancy
);

    localparam int DEPTH = 4;

    logic [15:0] fetch_pc;
    logic [15:0] pend_pc;
    logic        pending;
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;
    logic [31:0] entries [DEPTH];

    logic        issue;
    logic        resp_live;
    logic        head_valid;
    logic        bypass;
    logic        push;
    logic        pop;

    // Fetch issue, response acceptance and queue pop decisions
    always_comb begin
        resp_live  = pending & ~redirect & ~reset;
        head_valid = (count != 3'd0);
`ifdef FETCHQ_BYPASS_EN
        // Response goes straight to decode when nothing is queued ahead of it
        bypass     = resp_live & ~head_valid & ~stall;
`else
        bypass     = 1'b0;
`endif
        // Free space counts only settled entries plus the in-flight word;
        // a same-cycle pop is deliberately not credited
        issue      = ~reset & ~redirect &
                     (({1'b0, count} + {3'b000, pending}) < 4'd4);
        push       = resp_live & ~bypass;
        pop        = head_valid & ~stall & ~redirect & ~reset;
    end

    // Output presentation; everything reads zero while reset is held
    always_comb begin
        imem_req   = issue;
        imem_addr  = fetch_pc;
        inst_valid = ~reset & (head_valid | bypass);
        occupancy  = reset ? 3'd0 : count;
        inst       = 16'h0000;
        inst_pc    = 16'h0000;
        if (!reset && head_valid) begin
            inst    = entries[rd_ptr][15:0];
            inst_pc = entries[rd_ptr][31:16];
        end else if (bypass) begin
            inst    = imem_data;
            inst_pc = pend_pc;
        end
    end

    // Control state: fetch pc, in-flight tracking, pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= 16'h0000;
            pend_pc  <= 16'h0000;
            pending  <= 1'b0;
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
        end else if (redirect) begin
            // Flush: drop queue contents and the in-flight response
            fetch_pc <= redirect_pc;
            pending  <= 1'b0;
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            count    <= 3'd0;
        end else begin
            pending <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + 16'd1;
                pend_pc  <= fetch_pc;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Queue storage; push is already gated off by reset and redirect
    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= {pend_pc, imem_data};
        end
    end

endmodule
`default_nettype wire
